serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Uses a single full-adder cell with a registered carry between bit slices.
- Sits directly upstream of result consumers and downstream of operand sources.
- Replaces a WIDTH-wide ripple chain with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new addition; sampled on rising clk
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse, result valid
- sum  output  WIDTH  registered sum, held until the next accepted start completes
- cout  output  1  registered final carry-out, held with sum

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter all go to 0.
  - Reset takes effect immediately, at any time, including mid-RUN; the partial result is discarded and no done is generated.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch a, b into shift registers, carry<=cin, count<=0, go to RUN.
  - a, b and cin are not sampled at any other time.
- RUN (busy=1):
  - Each edge: s = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh, b_sh right by one.
  - Shift s into the MSB of the internal result register (result register shifts right), then count<=count+1.
  - After the edge that processes bit WIDTH-1: copy the result register to sum and the final carry to cout, then go to DONE.
  - start is ignored while in RUN.
- DONE (busy=0, done=1 for exactly one cycle):
  - Next edge goes to IDLE.
  - If start=1 during DONE, it is accepted exactly as in IDLE: operands are latched and the next state is RUN.
- Latency: start accepted at edge T → done high in the cycle following edge T+WIDTH. That is WIDTH+1 cycles from start to done, with busy high for exactly WIDTH cycles.
- Output hold: sum/cout change only on the edge entering DONE. Between results they hold the previous value. Internal shifting is never visible on sum.
- Arithmetic: {cout,sum} == a + b + cin (modulo 2^(WIDTH+1)), with all values unsigned.
- Counter width: $clog2(WIDTH+1) bits. No wrap occurs, because the counter resets on every accepted start.
- Back-to-back operation: start held high continuously gives one result every WIDTH+1 cycles.

Test Plan:
1. WIDTH=8, reset, then start with a=0x00, b=0x00, cin=0 → busy high 8 cycles, done pulse at cycle 9, sum=0x00, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Also a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Also a=100, b=27, cin=0 → sum=127, cout=0. Check each done arrives exactly 9 cycles after start.
3. Start a=0x0F, b=0x01, cin=0. Pulse start with a=0xFF, b=0xFF on the 3rd busy cycle → the second start is ignored; result sum=0x10, cout=0; only one done pulse; sum holds 0x10 afterwards.
4. Start a=0x80, b=0x80, cin=1, then assert rst for 1 cycle (asynchronously, mid-clock) after 4 busy cycles → busy/done/sum/cout go to 0 immediately, no done pulse. After release, a new start with a=0x01, b=0x02, cin=0 gives sum=0x03.
5. Hold start=1 continuously with the operand sequence (0x10, 0x20, 0), (0xF0, 0x20, 1) → done pulses 9 cycles apart. Results: sum=0x30, cout=0, then sum=0x11, cout=1.
6. WIDTH=4, exhaustive: all 512 combinations of a, b, cin → {cout,sum} matches a+b+cin for every combination, and every done arrives 5 cycles after its start.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, registered carry, LSB first.
// start/busy/done handshake; sum/cout update only on entry to DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s, maj, last;

  always_comb begin
    s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    maj  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q)
         | (b_sh_q[0] & carry_q);
    last = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {s, res_q[WIDTH-1:1]};
        carry_d = maj;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = res_d;
          cout_d  = maj;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 scenarios plus
// an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       st4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8),
    .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4),
    .a(a4), .b(b4), .cin(c4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, then check latency, busy length, result, single pulse.
  task automatic run8(input string tag, input logic [7:0] ta,
                      input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic ec);
    int n, nb;
    a8 = ta; b8 = tb; c8 = tc; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    n = 0; nb = 0;
    while (!done8 && n < 20) begin
      if (busy8) nb++;
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd8);
    check({tag, " busy"}, 32'(nb), 32'd8);
    check({tag, " result"}, 32'({cout8, sum8}), 32'({ec, es}));
    tick();
    check({tag, " pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int n, nd;
    tick();
    tick();
    check("reset outs", 32'({busy8, done8, cout8, sum8}), 32'd0);
    rst = 1'b0;
    tick();

    run8("t1 zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("t2 ff+1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("t2 a5+5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run8("t2 100+27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0);

    // start pulsed mid-run must be ignored
    a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    nd = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        st8 = 1'b0;
      end
      tick();
      if (done8) nd++;
    end
    check("t3 one done", 32'(nd), 32'd1);
    check("t3 hold", 32'({cout8, sum8}), 32'h010);

    // asynchronous reset mid-run
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b1; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t4 busy pre", 32'(busy8), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("t4 async rst", 32'({busy8, done8, cout8, sum8}), 32'd0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) nd++;
    end
    check("t4 no done", 32'(nd), 32'd0);
    run8("t4 after", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // start held high: results every WIDTH+1 cycles
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; st8 = 1'b1;
    tick();
    a8 = 8'hF0; b8 = 8'h20; c8 = 1'b1;
    n = 0;
    while (!done8 && n < 20) begin tick(); n++; end
    check("t5 lat1", 32'(n), 32'd8);
    check("t5 res1", 32'({cout8, sum8}), 32'h030);
    tick();
    st8 = 1'b0;
    n = 1;
    while (!done8 && n < 20) begin tick(); n++; end
    check("t5 gap", 32'(n), 32'd9);
    check("t5 res2", 32'({cout8, sum8}), 32'h111);
    tick();

    // WIDTH=4 exhaustive sweep
    for (int i = 0; i < 512; i++) begin
      int e;
      a4 = 4'(i); b4 = 4'(i >> 4); c4 = 1'(i >> 8);
      e = (i & 15) + ((i >> 4) & 15) + ((i >> 8) & 1);
      st4 = 1'b1;
      tick();
      st4 = 1'b0;
      n = 0;
      while (!done4 && n < 10) begin tick(); n++; end
      check($sformatf("t6 w4 %0d lat/res", i),
            32'(n * 32) + 32'({cout4, sum4}), 32'(4 * 32 + e));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
